mealy_seq_detector: RTL

//   Parametrised Mealy serial-pattern detector, successor to the fixed 2-state Mealy FSM.

---
 rtl/mealy_seq_detector.sv | 94 +++++++++
 1 files changed

// File: rtl/mealy_seq_detector.sv
// Mealy serial-pattern detector with an elaboration-time KMP transition table.
// Optional saturating match counter is enabled by defining SEQ_DET_COUNT_EN.
module mealy_seq_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_valid,
  output logic                         dout,
  output logic [$clog2(PATTERN_W)-1:0] state,
  output logic [CNT_W-1:0]             match_count
);

  // Handshake: din is consumed on every posedge where din_valid=1 and rst=0;
  // there is no backpressure, and dout is only meaningful in that same cycle.

  localparam int SW   = $clog2(PATTERN_W);
  localparam int LAST = PATTERN_W - 1;

  if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_width
    $error("mealy_seq_detector: PATTERN_W must be in 2..16");
  end

  // Longest suffix of (first k pattern bits + b) that is a proper prefix of PATTERN.
  function automatic int kmp_next(input int k, input bit b);
    bit [16:0]            t;
    logic [PATTERN_W-1:0] p;
    int                   n;
    int                   best;
    bit                   ok;
    p    = PATTERN;
    t    = '0;
    best = 0;
    for (int i = 0; i < k; i++) t[i] = p[PATTERN_W-1-i];
    t[k] = b;
    n    = k + 1;
    for (int l = 1; l < PATTERN_W; l++) begin
      if (l <= n) begin
        ok = 1'b1;
        for (int m = 0; m < l; m++)
          if (t[n-l+m] != p[PATTERN_W-1-m]) ok = 1'b0;
        if (ok) best = l;
      end
    end
    return best;
  endfunction

  // Table entry {k, b} holds the successor of state k on input bit b.
  logic [SW-1:0] nxt_tbl [2*PATTERN_W];

  for (genvar g = 0; g < 2 * PATTERN_W; g++) begin : g_tbl
    localparam int K  = g / 2;
    localparam bit B  = (g % 2) == 1;
    localparam bit FULL = (K == LAST) && (B == PATTERN[0]);
    localparam int NX = (FULL && !OVERLAP) ? 0 : kmp_next(K, B);
    assign nxt_tbl[g] = SW'(NX);
  end

  logic [SW-1:0] state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= '0;
    else     state <= state_nxt;
  end

  always_comb begin
    dout      = 1'b0;
    state_nxt = state;
    if (rst) begin
      state_nxt = '0;
    end else if (din_valid) begin
      state_nxt = nxt_tbl[{state, din}];
      dout      = (state == SW'(LAST)) && (din == PATTERN[0]);
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                         cnt_q <= '0;
    else if (dout && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule
